// File: rtl/fe_fetch.sv
// Front-end fetch stage: owns the fetch PC, issues one imem request per cycle under a
// credit limit, and queues in-order responses for decode; redirects flush via an epoch bit.
module fe_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] bp_pc,
    input  logic [63:0] bp_predicted_pc,
    input  logic        bp_predicted_taken,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_fault,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [63:0] dec_pc,
    output logic [31:0] dec_inst,
    output logic        dec_pred_taken,
    output logic [63:0] dec_pred_pc,
    output logic        dec_fault
);
    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN,
        ST_FAULT_STALL
    } state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] pred_pc;
        logic        pred_taken;
        logic        epoch;
    } tag_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] pred_pc;
        logic        pred_taken;
        logic        fault;
    } fq_entry_t;

    state_e           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic             epoch_q, epoch_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] fq_count_q, fq_count_d;
    logic [PTR_W-1:0] tag_wr_q, tag_rd_q;
    logic [PTR_W-1:0] fq_wr_q, fq_rd_q;

    tag_t             tag_mem_q [FQ_DEPTH];
    fq_entry_t        fq_mem_q  [FQ_DEPTH];

    logic [CNT_W:0]   credit_used;
    logic             req_ok;
    logic             accept;
    logic             rsp_take;
    logic             rsp_keep;
    logic             fq_nonempty;
    logic             fq_pop;
    tag_t             tag_head;
    fq_entry_t        fq_head;

    // Outstanding requests plus queued entries may never exceed the queue depth.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fq_count_q};
    assign req_ok      = !rst && (state_q == ST_RUN) && !redirect_valid
                         && (credit_used < (CNT_W + 1)'(FQ_DEPTH));
    assign accept      = req_ok && imem_req_ready;

    assign bp_pc          = pc_q;
    assign imem_req_addr  = pc_q;
    assign imem_req_valid = req_ok;

    assign tag_head = tag_mem_q[tag_rd_q];
    assign rsp_take = imem_rsp_valid && (inflight_q != '0);
    assign rsp_keep = rsp_take && (tag_head.epoch == epoch_q) && !redirect_valid;

    assign fq_head     = fq_mem_q[fq_rd_q];
    assign fq_nonempty = (fq_count_q != '0);
    assign dec_valid   = fq_nonempty && !redirect_valid;
    assign fq_pop      = dec_valid && dec_ready;

    assign dec_pc         = fq_nonempty ? fq_head.pc         : 64'h0;
    assign dec_inst       = fq_nonempty ? fq_head.inst       : 32'h0;
    assign dec_pred_pc    = fq_nonempty ? fq_head.pred_pc    : 64'h0;
    assign dec_pred_taken = fq_nonempty ? fq_head.pred_taken : 1'b0;
    assign dec_fault      = fq_nonempty ? fq_head.fault      : 1'b0;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(rsp_take);
        fq_count_d = fq_count_q + CNT_W'(rsp_keep) - CNT_W'(fq_pop);

        if (accept) begin
            pc_d = bp_predicted_pc;
        end
        if (rsp_keep && imem_rsp_fault) begin
            state_d = ST_FAULT_STALL;
        end
        // Redirect wins; the tag FIFO keeps draining so stale responses are dropped by epoch.
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            epoch_d    = ~epoch_q;
            fq_count_d = '0;
            state_d    = ST_RUN;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            epoch_q    <= 1'b0;
            inflight_q <= '0;
            fq_count_q <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fq_wr_q    <= '0;
            fq_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            inflight_q <= inflight_d;
            fq_count_q <= fq_count_d;
            if (accept) begin
                tag_wr_q <= tag_wr_q + PTR_W'(1);
            end
            if (rsp_take) begin
                tag_rd_q <= tag_rd_q + PTR_W'(1);
            end
            if (redirect_valid) begin
                fq_wr_q <= '0;
                fq_rd_q <= '0;
            end else begin
                if (rsp_keep) begin
                    fq_wr_q <= fq_wr_q + PTR_W'(1);
                end
                if (fq_pop) begin
                    fq_rd_q <= fq_rd_q + PTR_W'(1);
                end
            end
        end
    end

    // NOTE: storage arrays are not reset; pointers and counts define validity, and the
    // decode outputs are masked to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem_q[tag_wr_q] <= '{pc: pc_q, pred_pc: bp_predicted_pc,
                                     pred_taken: bp_predicted_taken, epoch: epoch_q};
        end
        if (rsp_keep) begin
            fq_mem_q[fq_wr_q] <= '{pc: tag_head.pc, inst: imem_rsp_data,
                                   pred_pc: tag_head.pred_pc,
                                   pred_taken: tag_head.pred_taken,
                                   fault: imem_rsp_fault};
        end
    end

endmodule

// File: tb/tb_fe_fetch.sv
// Directed bench for fe_fetch: in-order memory model with configurable latency and a
// pc+4 predictor with one optional taken branch.
module tb_fe_fetch;
    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] bp_pc;
    logic [63:0] bp_predicted_pc;
    logic        bp_predicted_taken;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_fault;
    logic        dec_valid;
    logic        dec_ready;
    logic [63:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_pred_taken;
    logic [63:0] dec_pred_pc;
    logic        dec_fault;

    fe_fetch #(
        .RESET_PC(64'h1000),
        .FQ_DEPTH(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .bp_pc             (bp_pc),
        .bp_predicted_pc   (bp_predicted_pc),
        .bp_predicted_taken(bp_predicted_taken),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .imem_rsp_fault    (imem_rsp_fault),
        .dec_valid         (dec_valid),
        .dec_ready         (dec_ready),
        .dec_pc            (dec_pc),
        .dec_inst          (dec_inst),
        .dec_pred_taken    (dec_pred_taken),
        .dec_pred_pc       (dec_pred_pc),
        .dec_fault         (dec_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Predictor: pc+4, except one configurable taken branch.
    logic        tk_en;
    logic [63:0] tk_from;
    logic [63:0] tk_to;
    assign bp_predicted_taken = tk_en && (bp_pc == tk_from);
    assign bp_predicted_pc    = bp_predicted_taken ? tk_to : bp_pc + 64'd4;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cyc;
    int          lat;
    logic        fault_en;
    logic [63:0] fault_addr;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_mem();
        pend_t p;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_fault = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(p.addr);
            imem_rsp_fault = fault_en && (p.addr == fault_addr);
        end
    endtask

    // Inputs for the current cycle are already set; record acceptance and advance one cycle.
    task automatic tick();
        pend_t p;
        if (imem_req_valid && imem_req_ready) begin
            p.addr = imem_req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect_valid = 1'b0;
        drive_mem();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_fault = 1'b0;
        imem_rsp_data  = 32'h0;
        pend.delete();
        #1;
        check("rst_async_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("rst_async_dec_valid", {63'h0, dec_valid}, 64'h0);
        check("rst_dec_pc", dec_pc, 64'h0);
        check("rst_dec_inst", {32'h0, dec_inst}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_bp_pc", bp_pc, 64'h1000);
        rst = 1'b0;
        cyc = 0;
        #1;
    endtask

    logic [63:0] e;

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        imem_rsp_fault = 1'b0;
        dec_ready = 1'b1;
        tk_en = 1'b0;
        tk_from = 64'h0;
        tk_to = 64'h0;
        lat = 1;
        fault_en = 1'b0;
        fault_addr = 64'h0;
        cyc = 0;

        // Steady state: 1-cycle memory, decode always ready.
        do_reset();
        check("rst_dec_pred_pc", dec_pred_pc, 64'h0);
        check("rst_dec_pred_taken", {63'h0, dec_pred_taken}, 64'h0);
        check("rst_dec_fault", {63'h0, dec_fault}, 64'h0);
        check("t1_first_req_valid", {63'h0, imem_req_valid}, 64'h1);
        for (int k = 0; k < 6; k++) begin
            e = 64'h1000 + 64'(4 * k);
            check("t1_req_addr", imem_req_addr, e);
            if (k >= 2) begin
                e = 64'h1000 + 64'(4 * (k - 2));
                check("t1_dec_valid", {63'h0, dec_valid}, 64'h1);
                check("t1_dec_pc", dec_pc, e);
                check("t1_dec_inst", {32'h0, dec_inst}, {32'h0, inst_of(e)});
                check("t1_dec_pred_pc", dec_pred_pc, e + 64'd4);
            end else begin
                check("t1_dec_valid_early", {63'h0, dec_valid}, 64'h0);
            end
            tick();
        end

        // Decode stalled: credit caps issue at four, then resumes one cycle after dec_ready.
        dec_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check("t2_req_valid", {63'h0, imem_req_valid}, 64'h1);
            check("t2_req_addr", imem_req_addr, 64'h1000 + 64'(4 * k));
            tick();
        end
        check("t2_capped_c4", {63'h0, imem_req_valid}, 64'h0);
        tick();
        check("t2_capped_c5", {63'h0, imem_req_valid}, 64'h0);
        check("t2_head_c5", dec_pc, 64'h1000);
        tick();
        dec_ready = 1'b1;
        #1;
        check("t2_capped_c6", {63'h0, imem_req_valid}, 64'h0);
        check("t2_head_c6", dec_pc, 64'h1000);
        tick();
        check("t2_resume_valid", {63'h0, imem_req_valid}, 64'h1);
        check("t2_resume_addr", imem_req_addr, 64'h1010);
        check("t2_head_c7", dec_pc, 64'h1004);
        tick();
        check("t2_head_c8", dec_pc, 64'h1008);
        tick();
        check("t2_head_c9", dec_pc, 64'h100C);
        tick();
        check("t2_head_c10", dec_pc, 64'h1010);

        // Memory not ready for three cycles: address held, pc advances only on accept.
        do_reset();
        imem_req_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("t3_hold_valid", {63'h0, imem_req_valid}, 64'h1);
            check("t3_hold_addr", imem_req_addr, 64'h1000);
            tick();
        end
        imem_req_ready = 1'b1;
        #1;
        check("t3_accept_addr", imem_req_addr, 64'h1000);
        tick();
        check("t3_next_addr", imem_req_addr, 64'h1004);
        check("t3_dec_not_yet", {63'h0, dec_valid}, 64'h0);
        tick();
        check("t3_dec_valid", {63'h0, dec_valid}, 64'h1);
        check("t3_dec_pc", dec_pc, 64'h1000);

        // Three in flight at 3-cycle latency, then redirect: stale responses never reach decode.
        lat = 3;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check("t4_req_addr", imem_req_addr, 64'h1000 + 64'(4 * k));
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000;
        #1;
        check("t4_redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("t4_redir_dec_valid", {63'h0, dec_valid}, 64'h0);
        tick();
        check("t4_new_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("t4_new_req_addr", imem_req_addr, 64'h8000);
        for (int k = 0; k < 4; k++) begin
            check("t4_stale_dropped", {63'h0, dec_valid}, 64'h0);
            tick();
        end
        check("t4_dec_valid", {63'h0, dec_valid}, 64'h1);
        check("t4_dec_pc", dec_pc, 64'h8000);
        check("t4_dec_pred_pc", dec_pred_pc, 64'h8004);

        // Fault on 0x1008: delivered with dec_fault, issue stops until redirect.
        lat = 1;
        fault_en = 1'b1;
        fault_addr = 64'h1008;
        do_reset();
        tick();
        tick();
        tick();
        check("t5_last_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("t5_last_req_addr", imem_req_addr, 64'h100C);
        check("t5_pre_fault_dec", {63'h0, dec_fault}, 64'h0);
        tick();
        dec_ready = 1'b0;
        #1;
        check("t5_stall_req_c4", {63'h0, imem_req_valid}, 64'h0);
        check("t5_fault_dec_valid", {63'h0, dec_valid}, 64'h1);
        check("t5_fault_dec_pc", dec_pc, 64'h1008);
        check("t5_fault_flag", {63'h0, dec_fault}, 64'h1);
        tick();
        check("t5_stall_req_c5", {63'h0, imem_req_valid}, 64'h0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h2000;
        #1;
        check("t5_redir_dec_valid", {63'h0, dec_valid}, 64'h0);
        tick();
        dec_ready = 1'b1;
        #1;
        check("t5_resume_valid", {63'h0, imem_req_valid}, 64'h1);
        check("t5_resume_addr", imem_req_addr, 64'h2000);
        check("t5_flushed", {63'h0, dec_valid}, 64'h0);
        tick();
        tick();
        check("t5_new_dec_pc", dec_pc, 64'h2000);
        check("t5_new_dec_fault", {63'h0, dec_fault}, 64'h0);

        // Taken prediction 0x100C -> 0x4000, then wrap from the top of the address space.
        fault_en = 1'b0;
        tk_en = 1'b1;
        tk_from = 64'h100C;
        tk_to = 64'h4000;
        do_reset();
        tick();
        tick();
        tick();
        check("t6_req_branch", imem_req_addr, 64'h100C);
        tick();
        check("t6_req_target", imem_req_addr, 64'h4000);
        check("t6_dec_nt", {63'h0, dec_pred_taken}, 64'h0);
        tick();
        check("t6_dec_branch_pc", dec_pc, 64'h100C);
        check("t6_dec_taken", {63'h0, dec_pred_taken}, 64'h1);
        check("t6_dec_target", dec_pred_pc, 64'h4000);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check("t6_redir_dec_valid", {63'h0, dec_valid}, 64'h0);
        check("t6_redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
        tick();
        check("t6_top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("t6_wrap_addr", imem_req_addr, 64'h0);
        tick();
        check("t6_dec_top_pc", dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t6_dec_top_pred", dec_pred_pc, 64'h0);
        tick();
        check("t6_dec_wrap_pc", dec_pc, 64'h0);
        check("t6_dec_wrap_pred", dec_pred_pc, 64'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fe_fetch.md
# fe_fetch

Front-end fetch stage of the Z480 P7 core: owns the architectural fetch PC, issues one 4-byte instruction request per cycle to the instruction memory port, and buffers returned instructions in an in-order fetch queue feeding decode. It sits directly upstream of `fe_bpred`: it presents the current fetch PC to the predictor and takes the predicted next PC and taken bit. Backend redirects flush the stage and discard stale in-flight responses via an epoch bit.

## Interface
- `RESET_PC`, 64'h0: fetch PC loaded on reset.
- `FQ_DEPTH`, 4: fetch queue entries; also the cap on outstanding requests plus queued entries. Power of two, ≥2.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `redirect_valid` in 1: backend redirect/flush this cycle.
- `redirect_pc` in 64: new fetch PC.
- `bp_pc` out 64: current fetch PC to the predictor.
- `bp_predicted_pc` in 64: predicted next PC for `bp_pc`.
- `bp_predicted_taken` in 1: prediction direction.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 64: request address (equals `bp_pc`).
- `imem_rsp_valid` in 1: response, in request order, always accepted (no ready).
- `imem_rsp_data` in 32: instruction word.
- `imem_rsp_fault` in 1: access fault for this response.
- `dec_valid` out 1: queue head valid.
- `dec_ready` in 1: decode accepts head.
- `dec_pc` out 64, `dec_inst` out 32, `dec_pred_taken` out 1, `dec_pred_pc` out 64, `dec_fault` out 1: head entry fields.

## Operation
- State: `pc`, `epoch` (1 bit), `inflight` count (0..FQ_DEPTH), tag FIFO (FQ_DEPTH × {pc, pred_pc, pred_taken, epoch}), fetch queue (FQ_DEPTH × {pc, inst, pred_pc, pred_taken, fault}), FSM {RUN, FAULT_STALL}.
- Issue: `imem_req_valid` = RUN & !redirect_valid & (inflight + fq_count < FQ_DEPTH), using registered counts. Request accepted when valid & ready; then the tag FIFO pushes {pc, bp_predicted_pc, bp_predicted_taken, epoch}, `pc` ← `bp_predicted_pc`, and inflight increments.
- Stable request: while valid & !ready, `imem_req_addr` holds. The only retraction allowed is by redirect.
- Response: pops the tag FIFO and decrements inflight. If tag epoch == current epoch, push {tag.pc, rsp_data, tag.pred_pc, tag.pred_taken, rsp_fault} to the queue; otherwise drop. Credit rule guarantees the queue never overflows.
- Fault: a current-epoch response with `imem_rsp_fault` = 1 moves RUN → FAULT_STALL. No further requests issue. Responses still drain.
- Redirect (highest priority): `pc` ← `redirect_pc`, `epoch` toggles, fetch queue empties, FSM → RUN, and the tag FIFO and inflight are kept so stale responses drain and are dropped.
- Dequeue: `dec_valid` = queue non-empty & !redirect_valid. Pop on dec_valid & dec_ready.
- Simultaneous push/pop: both occur and the count is unchanged. Simultaneous accept and response: inflight unchanged.
- Address arithmetic is 64-bit modulo 2^64. Wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal.

## Timing
- Reset values: pc = RESET_PC, epoch = 0, inflight = 0, queue empty, FSM = RUN, `imem_req_valid` = 0, `dec_valid` = 0, all `dec_*` data = 0.
- First request is asserted in the first cycle after `rst` deasserts. Reset asserted mid-operation clears all state immediately, including in-flight tracking; imem must also be reset.
- Memory latency is ≥1 cycle. A response can arrive at earliest in the cycle after acceptance.
- Response → `dec_valid`: 1 cycle (registered queue).
- Redirect in cycle N: no request and no dequeue in N. A response in N is dropped as stale. First request to `redirect_pc` is in N+1.
- Steady state with 1-cycle memory and `dec_ready` = 1 gives one instruction per cycle.

## Test plan
- Reset, RESET_PC = 0x1000, predictor pc+4, 1-cycle memory, dec_ready = 1 → requests 0x1000, 0x1004, 0x1008…; dec_pc follows 1 cycle after each response, one per cycle, dec_pred_pc = pc+4.
- dec_ready = 0 → at most 4 requests issue, then imem_req_valid stays low. Raising dec_ready resumes issue next cycle; no entry is lost or duplicated.
- imem_req_ready low for 3 cycles → imem_req_addr held constant; pc advances only on acceptance.
- 3 requests in flight (3-cycle latency), then redirect to 0x8000 → the 3 stale responses never reach decode; the next dec_pc is 0x8000; dec_valid is 0 in the redirect cycle.
- Response for 0x1008 with fault = 1 → entry delivered with dec_fault = 1, no further requests. Redirect to 0x2000 → fetch resumes at 0x2000.
- Predictor taken from 0x100C to 0x4000, and start PC 0xFFFF_FFFF_FFFF_FFFC → request sequence 0x100C, 0x4000 with dec_pred_taken = 1 on the 0x100C entry; separately the PC wraps to 0x0.
